// File: rtl/pred_calc_sequencer_pkg.sv
// Shared constants and FSM encoding for the prediction-calculation sequencer.
// Geometry is one 4:2:0 macroblock: four luma blocks, then Cb and Cr.
package pred_calc_sequencer_pkg;

  localparam int MB_BLOCKS    = 6;
  localparam int BLK_ROWS     = 8;
  localparam int ROW_WORDS    = 4;
  localparam int LAST_Y_BLOCK = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pred_seq_delay_line.sv
// Fixed-depth shift register aligning write strobes with their retrieve addresses.
// Shifts every cycle, so stall bubbles travel through it unchanged; sync reset clears all stages.
module pred_seq_delay_line #(
  parameter int LAT = 3,
  parameter int W   = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[LAT-1];

endmodule

// File: rtl/pred_calc_sequencer.sv
// Walks one macroblock of retrieve addresses, mirrors them PIPE_LAT cycles later as writes, and
// tracks the two-bank prediction store. Optional stall counter: PRED_SEQ_STALL_CNT_EN.
module pred_calc_sequencer
  import pred_calc_sequencer_pkg::*;
#(
  parameter int PIPE_LAT   = 3,
  parameter int NUM_BLOCKS = MB_BLOCKS
) (
  input  logic       Clk_I,
  input  logic       Reset_I,
  input  logic       Start_I,
  output logic       Ready_O,
  input  logic       Data_Valid_I,
  input  logic       Bank_Release_I,
  output logic [3:0] Block_Counter_O,
  output logic [3:0] Row_Counter_O,
  output logic [1:0] Column_Counter_O,
  output logic       Retrieve_En_O,
  output logic [3:0] Wr_Block_Counter_O,
  output logic [3:0] Wr_Row_Counter_O,
  output logic [1:0] Wr_Column_Counter_O,
  output logic       Write_En_O,
  output logic       Bank_Sel_Flag_O,
  output logic [1:0] Bank_Full_O,
  output logic       Busy_O,
  output logic       Done_O
`ifdef PRED_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] Stall_Count_O
`endif
);

  state_t      state;
  logic        rd_ptr;
  logic        accept, strobe, last_addr, release_ok;
  logic [3:0]  nxt_blk, nxt_row, cur_blk, cur_row, inc_blk, inc_row;
  logic [1:0]  nxt_col, cur_col, inc_col;
  logic [1:0]  full_nxt;
  logic [10:0] wr_bus;

  assign Busy_O     = (state != IDLE);
  assign Ready_O    = (state == IDLE) && !Bank_Full_O[Bank_Sel_Flag_O];
  assign accept     = Start_I && Ready_O;
  assign strobe     = Data_Valid_I && (accept || state == RUN);
  assign release_ok = Bank_Release_I && (Bank_Full_O != 2'b00);

  // The final write address occurs exactly once per macroblock, so it marks completion.
  assign Done_O = (state == DRAIN) && Write_En_O &&
                  (Wr_Block_Counter_O == 4'(NUM_BLOCKS - 1)) &&
                  (Wr_Row_Counter_O == 4'(BLK_ROWS - 1)) &&
                  (Wr_Column_Counter_O == 2'(ROW_WORDS - 1));

  // cur_* is the address this cycle's strobe would issue; a fresh start always begins at zero.
  always_comb begin
    cur_blk = accept ? 4'd0 : nxt_blk;
    cur_row = accept ? 4'd0 : nxt_row;
    cur_col = accept ? 2'd0 : nxt_col;
    inc_blk = cur_blk;
    inc_row = cur_row;
    inc_col = cur_col + 2'd1;
    if (cur_col == 2'(ROW_WORDS - 1)) begin
      if (cur_row == 4'(BLK_ROWS - 1)) begin
        inc_row = 4'd0;
        inc_blk = (cur_blk == 4'(NUM_BLOCKS - 1)) ? 4'd0 : cur_blk + 4'd1;
      end else begin
        inc_row = cur_row + 4'd1;
      end
    end
  end

  assign last_addr = (cur_blk == 4'(NUM_BLOCKS - 1)) && (cur_row == 4'(BLK_ROWS - 1)) &&
                     (cur_col == 2'(ROW_WORDS - 1));

  // Release clears the read bank and completion sets the write bank; both may land together.
  always_comb begin
    full_nxt = Bank_Full_O;
    if (release_ok) full_nxt[rd_ptr] = 1'b0;
    if (Done_O) full_nxt[Bank_Sel_Flag_O] = 1'b1;
  end

  always_ff @(posedge Clk_I) begin
    if (Reset_I) begin
      state            <= IDLE;
      rd_ptr           <= 1'b0;
      Bank_Sel_Flag_O  <= 1'b0;
      Bank_Full_O      <= 2'b00;
      Retrieve_En_O    <= 1'b0;
      Block_Counter_O  <= 4'd0;
      Row_Counter_O    <= 4'd0;
      Column_Counter_O <= 2'd0;
      nxt_blk          <= 4'd0;
      nxt_row          <= 4'd0;
      nxt_col          <= 2'd0;
    end else begin
      Bank_Full_O   <= full_nxt;
      Retrieve_En_O <= strobe;
      if (release_ok) rd_ptr <= ~rd_ptr;
      if (strobe) begin
        Block_Counter_O  <= cur_blk;
        Row_Counter_O    <= cur_row;
        Column_Counter_O <= cur_col;
        nxt_blk          <= inc_blk;
        nxt_row          <= inc_row;
        nxt_col          <= inc_col;
      end else if (accept) begin
        nxt_blk <= 4'd0;
        nxt_row <= 4'd0;
        nxt_col <= 2'd0;
      end
      case (state)
        IDLE:  if (accept) state <= RUN;
        RUN:   if (strobe && last_addr) state <= DRAIN;
        DRAIN: begin
          if (Done_O) begin
            state           <= IDLE;
            Bank_Sel_Flag_O <= ~Bank_Sel_Flag_O;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRED_SEQ_STALL_CNT_EN
  always_ff @(posedge Clk_I) begin
    if (Reset_I || accept) begin
      Stall_Count_O <= 16'd0;
    end else if (state == RUN && !Data_Valid_I && Stall_Count_O != 16'hFFFF) begin
      Stall_Count_O <= Stall_Count_O + 16'd1;
    end
  end
`endif

  pred_seq_delay_line #(
    .LAT (PIPE_LAT),
    .W   (11)
  ) u_delay (
    .clk  (Clk_I),
    .rst  (Reset_I),
    .din  ({Retrieve_En_O, Block_Counter_O, Row_Counter_O, Column_Counter_O}),
    .dout (wr_bus)
  );

  assign {Write_En_O, Wr_Block_Counter_O, Wr_Row_Counter_O, Wr_Column_Counter_O} = wr_bus;

endmodule

// File: tb/tb_pred_calc_sequencer.sv
// Self-checking bench: scoreboard of retrieve/write addresses plus per-scenario inline checks.
module tb_pred_calc_sequencer;

  localparam int PIPE_LAT = 3;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] r;
    logic [1:0] c;
  } addr_t;

  typedef struct {
    addr_t a;
    int    cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst, start, dv, rel;
  logic       ready, ret, we, sel, busy, done;
  logic [3:0] blk, row, wblk, wrow;
  logic [1:0] col, wcol, full;
`ifdef PRED_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic  mon_en = 1'b0;
  addr_t ret_q[$];
  wr_t   wr_q[$];
  addr_t last_a = {4'd5, 4'd7, 2'd3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pred_calc_sequencer #(
    .PIPE_LAT   (PIPE_LAT),
    .NUM_BLOCKS (6)
  ) dut (
    .Clk_I               (clk),
    .Reset_I             (rst),
    .Start_I             (start),
    .Ready_O             (ready),
    .Data_Valid_I        (dv),
    .Bank_Release_I      (rel),
    .Block_Counter_O     (blk),
    .Row_Counter_O       (row),
    .Column_Counter_O    (col),
    .Retrieve_En_O       (ret),
    .Wr_Block_Counter_O  (wblk),
    .Wr_Row_Counter_O    (wrow),
    .Wr_Column_Counter_O (wcol),
    .Write_En_O          (we),
    .Bank_Sel_Flag_O     (sel),
    .Bank_Full_O         (full),
    .Busy_O              (busy),
    .Done_O              (done)
`ifdef PRED_SEQ_STALL_CNT_EN
    ,
    .Stall_Count_O       (stall_cnt)
`endif
  );

  // Scoreboard monitor: every retrieve must match the next expected address and reappear
  // as a write exactly PIPE_LAT cycles later; Done must coincide with the final write.
  always @(negedge clk) begin
    addr_t got, e;
    wr_t   w;
    logic  exp_we, exp_done;
    if (mon_en) begin
      got = {blk, row, col};
      if (ret === 1'b1) begin
        checks++;
        if (ret_q.size() == 0) begin
          errors++;
          $display("FAIL retrieve_unexpected: strobe at cycle %0d addr %h, none expected", cyc, got);
        end else begin
          e = ret_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL retrieve_addr: cycle %0d got %h expected %h", cyc, got, e);
          end
          wr_q.push_back('{a: e, cyc: cyc + PIPE_LAT});
        end
      end
      while (wr_q.size() > 0 && wr_q[0].cyc < cyc) void'(wr_q.pop_front());
      exp_we   = (wr_q.size() > 0 && wr_q[0].cyc == cyc);
      exp_done = 1'b0;
      checks++;
      if (we !== exp_we) begin
        errors++;
        $display("FAIL write_en: cycle %0d got %b expected %b", cyc, we, exp_we);
      end
      if (exp_we) begin
        w = wr_q.pop_front();
        exp_done = (w.a == last_a);
        checks++;
        if ({wblk, wrow, wcol} !== w.a) begin
          errors++;
          $display("FAIL write_addr: cycle %0d got %h expected %h", cyc, {wblk, wrow, wcol}, w.a);
        end
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done_pulse: cycle %0d got %b expected %b", cyc, done, exp_done);
      end
    end
  end

  task automatic push_mb();
    for (int b = 0; b < 6; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 4; c++)
          ret_q.push_back({4'(b), 4'(r), 2'(c)});
  endtask

  task automatic start_mb();
    @(negedge clk);
    push_mb();
    start = 1'b1;
    dv    = 1'b1;
  endtask

  task automatic pulse_release();
    @(negedge clk);
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
  endtask

  // Runs one macroblock with valid held high; optionally releases a bank on the Done cycle.
  task automatic run_mb(input bit rel_on_done, output int done_k);
    done_k = -1;
    start_mb();
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_k = k;
        if (rel_on_done) rel = 1'b1;
        break;
      end
    end
    checks++;
    if (done_k < 0) begin
      errors++;
      $display("FAIL mb_timeout: no Done within 300 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dv = 1'b0; rel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ret, we, busy, done, sel, full} !== 6'b0 || {blk, row, col, wblk, wrow, wcol} !== 20'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ret%b we%b busy%b done%b sel%b full%b ctr %h expected all 0",
               ret, we, busy, done, sel, full, {blk, row, col, wblk, wrow, wcol});
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
`ifdef PRED_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    mon_en = 1'b1;
  endtask

  task automatic test_single_mb();
    int dones = 0;
    start_mb();
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (k == 1) begin
        checks++;
        if (ret !== 1'b1 || {blk, row, col} !== 10'd0) begin
          errors++;
          $display("FAIL first_strobe: got ret %b addr %h expected 1 / 000", ret, {blk, row, col});
        end
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (we !== (k == 4)) begin
          errors++;
          $display("FAIL first_write_lat: k=%0d got we %b expected %b", k, we, k == 4);
        end
      end
      if (k == 33) begin
        checks++;
        if ({blk, row, col} !== {4'd1, 4'd0, 2'd0}) begin
          errors++;
          $display("FAIL strobe33: got %0d/%0d/%0d expected 1/0/0", blk, row, col);
        end
      end
      if (k == 129) begin
        checks++;
        if (blk !== 4'd4) begin
          errors++;
          $display("FAIL strobe129: got block %0d expected 4", blk);
        end
      end
      if (k == 192) begin
        checks++;
        if (ret !== 1'b1 || {blk, row, col} !== {4'd5, 4'd7, 2'd3}) begin
          errors++;
          $display("FAIL strobe192: got ret %b %0d/%0d/%0d expected 1 5/7/3", ret, blk, row, col);
        end
      end
      if (k == 193) begin
        checks++;
        if (ret !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL drain: got ret %b busy %b expected 0 1", ret, busy);
        end
      end
      if (k == 195) begin
        checks++;
        if (done !== 1'b1 || we !== 1'b1) begin
          errors++;
          $display("FAIL done_cycle: got done %b we %b expected 1 1", done, we);
        end
      end
      if (k == 196) begin
        checks++;
        if (full !== 2'b01 || sel !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
          errors++;
          $display("FAIL after_mb1: got full %b sel %b busy %b ready %b expected 01 1 0 1",
                   full, sel, busy, ready);
        end
      end
    end
    checks++;
    if (dones != 1 || ret_q.size() != 0) begin
      errors++;
      $display("FAIL mb1_counts: got %0d done pulses, %0d strobes missing; expected 1, 0",
               dones, ret_q.size());
    end
  endtask

  task automatic test_stall();
    int done_k = -1;
    start_mb();
    for (int k = 1; k <= 210; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (k >= 11 && k <= 15) begin
        checks++;
        if (ret !== 1'b0 || {blk, row, col} !== {4'd0, 4'd2, 2'd1}) begin
          errors++;
          $display("FAIL stall_hold: k=%0d got ret %b %0d/%0d/%0d expected 0 0/2/1",
                   k, ret, blk, row, col);
        end
      end
      if (k == 16) begin
        checks++;
        if (ret !== 1'b1 || col !== 2'd2) begin
          errors++;
          $display("FAIL stall_resume: got ret %b col %0d expected 1 2", ret, col);
        end
      end
      if (k == 201) begin
        checks++;
        if (full !== 2'b11 || sel !== 1'b0 || ready !== 1'b0) begin
          errors++;
          $display("FAIL both_full: got full %b sel %b ready %b expected 11 0 0", full, sel, ready);
        end
`ifdef PRED_SEQ_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd5) begin
          errors++;
          $display("FAIL stall_count: got %0d expected 5", stall_cnt);
        end
`endif
      end
      dv = !(k >= 10 && k <= 14);
    end
    checks++;
    if (done_k != 200) begin
      errors++;
      $display("FAIL stall_done_time: got k=%0d expected 200", done_k);
    end
  endtask

  task automatic test_bank_full();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ret !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: got busy %b ret %b expected 0 0", busy, ret);
    end
    pulse_release();
    checks++;
    if (full !== 2'b10 || ready !== 1'b1 || sel !== 1'b0) begin
      errors++;
      $display("FAIL release1: got full %b ready %b sel %b expected 10 1 0", full, ready, sel);
    end
  endtask

  task automatic test_release_on_done();
    int dk;
    run_mb(1'b0, dk);
    pulse_release();
    checks++;
    if (full !== 2'b01) begin
      errors++;
      $display("FAIL release_rd1: got full %b expected 01", full);
    end
`ifdef PRED_SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cleared: got %0d expected 0", stall_cnt);
    end
`endif
    run_mb(1'b1, dk);
    @(negedge clk);
    rel = 1'b0;
    checks++;
    if (full !== 2'b10 || sel !== 1'b0 || ready !== 1'b1 || dk != 195) begin
      errors++;
      $display("FAIL release_on_done: got full %b sel %b ready %b done_k %0d expected 10 0 1 195",
               full, sel, ready, dk);
    end
    pulse_release();
    pulse_release();
    checks++;
    if (full !== 2'b00) begin
      errors++;
      $display("FAIL release_empty: got full %b expected 00", full);
    end
    // An ignored release must not move the read pointer: the next fill lands in bank 0.
    run_mb(1'b0, dk);
    pulse_release();
    checks++;
    if (full !== 2'b00) begin
      errors++;
      $display("FAIL rd_ptr_hold: got full %b expected 00", full);
    end
    run_mb(1'b0, dk);
    @(negedge clk);
    checks++;
    if (full !== 2'b10 || sel !== 1'b0) begin
      errors++;
      $display("FAIL prefill: got full %b sel %b expected 10 0", full, sel);
    end
  endtask

  task automatic test_reset_mid();
    wr_t keep[$];
    int  wes = 0;
    start_mb();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (ret !== 1'b1 || {blk, row, col} !== {4'd3, 4'd0, 2'd3}) begin
      errors++;
      $display("FAIL strobe100: got ret %b %0d/%0d/%0d expected 1 3/0/3", ret, blk, row, col);
    end
    #1;
    rst = 1'b1;
    ret_q.delete();
    foreach (wr_q[i]) if (wr_q[i].cyc <= cyc) keep.push_back(wr_q[i]);
    wr_q = keep;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ret, we, busy, done, sel, full} !== 6'b0 || {blk, row, col, wblk, wrow, wcol} !== 20'b0) begin
      errors++;
      $display("FAIL mid_reset: got ret%b we%b busy%b done%b sel%b full%b ctr %h expected all 0",
               ret, we, busy, done, sel, full, {blk, row, col, wblk, wrow, wcol});
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (we === 1'b1) wes++;
    end
    checks++;
    if (wes != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: got %0d writes busy %b expected 0 0", wes, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_mb();
    test_stall();
    test_bank_full();
    test_release_on_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_calc_sequencer.md
Name: pred_calc_sequencer

Overview:
- Sequences one macroblock of prediction calculation through the prediction-calculation address generator.
- Drives its block/row/column counters and bank-select flag, and issues retrieve and delayed write strobes.
- Manages the two-bank (double-buffered) prediction store shared with the downstream consumer.
- Sits between the motion-compensation fetch pipeline and the prediction buffer.

Parameters:
- PIPE_LAT, 3, cycles from a retrieve strobe to its matching write strobe (range 1..8)
- NUM_BLOCKS, 6, blocks per macroblock (0-3 Y, 4 Cb, 5 Cr; 4:2:0)

Ports:
- Clk_I  in  1  clock
- Reset_I  in  1  reset; one clock, synchronous, active-high
- Start_I  in  1  request to process one macroblock
- Ready_O  out  1  high when Start_I will be accepted
- Data_Valid_I  in  1  reference data available this cycle; low stalls the retrieve side
- Bank_Release_I  in  1  consumer frees the oldest full bank
- Block_Counter_O  out  4  retrieve-side block index
- Row_Counter_O  out  4  retrieve-side row (0..7; bit 3 always 0)
- Column_Counter_O  out  2  retrieve-side word column
- Retrieve_En_O  out  1  counters valid; read the retrieve address
- Wr_Block_Counter_O  out  4  write-side copy of the block counter, delayed PIPE_LAT cycles
- Wr_Row_Counter_O  out  4  write-side copy of the row counter, delayed PIPE_LAT cycles
- Wr_Column_Counter_O  out  2  write-side copy of the column counter, delayed PIPE_LAT cycles
- Write_En_O  out  1  Retrieve_En_O delayed PIPE_LAT cycles
- Bank_Sel_Flag_O  out  1  bank currently being written
- Bank_Full_O  out  2  per-bank full flags
- Busy_O  out  1  state is not IDLE
- Done_O  out  1  one-cycle pulse on the final write of the macroblock

Behaviour:
- Reset values: all outputs 0; state IDLE; read-bank pointer 0; delay pipe cleared.
- Reset mid-operation aborts the macroblock, empties both banks and drops any strobes in flight.
- Ready_O = (state==IDLE) && !Bank_Full_O[Bank_Sel_Flag_O].
- Start_I while Ready_O is low is ignored; it is not queued.
- States:
  - IDLE -> RUN when Start_I && Ready_O.
  - RUN: each cycle with Data_Valid_I high, assert registered Retrieve_En_O and advance the counters. Column 0..3, then row 0..7, then block 0..NUM_BLOCKS-1. Order: column fastest, then row, then block.
  - RUN with Data_Valid_I low: hold the counters and deassert Retrieve_En_O.
  - RUN -> DRAIN after the strobe for block 5, row 7, column 3.
  - DRAIN: wait until the final Write_En_O has issued.
  - DRAIN -> IDLE on the final Write_En_O, which is the same cycle as Done_O.
- Latency:
  - First Retrieve_En_O appears the cycle after Start_I is accepted.
  - 192 retrieve strobes per macroblock.
  - Write_En_O and the Wr_* counters equal Retrieve_En_O and the counters delayed exactly PIPE_LAT cycles.
  - The delay pipe shifts every cycle, so stall bubbles propagate through it.
- Completion (the cycle Done_O is high):
  - Bank_Full_O[Bank_Sel_Flag_O] is set.
  - Bank_Sel_Flag_O toggles, taking effect the next cycle.
- Bank release:
  - Bank_Release_I clears Bank_Full_O[read pointer] and toggles the read pointer.
  - If no bank is full, Bank_Release_I is ignored.
- Release and completion in the same cycle: both take effect; the release clears the read-pointer bank, the completion sets the write bank.
- Both banks full: Ready_O stays low until a release.
- Counter widths match the address generator inputs. The sequencer never emits block values 6..15 or row values above 7.

Optional Feature:
- Macro: PRED_SEQ_STALL_CNT_EN.
- When defined:
  - Extra output Stall_Count_O [15:0] counts RUN-state cycles with Data_Valid_I low.
  - It clears on accepted Start_I and on reset, and saturates at 16'hFFFF.
  - It holds its value after Done_O.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - constants MB_BLOCKS=6, BLK_ROWS=8, ROW_WORDS=4, LAST_Y_BLOCK=3
  - FSM state encoding for IDLE, RUN, DRAIN
- Sub-module pred_seq_delay_line: a PIPE_LAT-deep shift register carrying {enable, block, row, column}, cleared by Reset_I.

Test Plan:
- Start at cycle 0, Data_Valid_I held high, PIPE_LAT=3 -> Retrieve_En_O high cycles 1..192; Write_En_O high cycles 4..195; Done_O at cycle 195. Bank_Full_O=2'b01 and Bank_Sel_Flag_O=1 from cycle 196.
- Counter order check -> strobe 33 shows block 1, row 0, column 0; strobe 129 shows block 4; strobe 192 shows block 5, row 7, column 3.
- Data_Valid_I low for 5 cycles after strobe 10 -> counters hold at block 0, row 2, column 1 (strobe 10's value); Done_O delayed by 5 cycles. With PRED_SEQ_STALL_CNT_EN, Stall_Count_O=5.
- Two macroblocks with no release -> Bank_Full_O=2'b11, Ready_O=0, third Start_I ignored. Bank_Release_I -> Bank_Full_O=2'b10, Ready_O=1, Bank_Sel_Flag_O=0.
- Bank_Release_I on the Done_O cycle of macroblock 2, with bank 0 full -> next cycle Bank_Full_O=2'b10.
- Reset_I asserted at strobe 100 -> next cycle all outputs 0, state IDLE; no further Write_En_O from that macroblock.
